// File: rtl/fewcore_pkg.sv
// Shared load/store decode constants and LSU state encoding.
// Execute's load decode also uses the opcode and funct3 constants defined here.
package fewcore_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // size: 00 byte, 01 half, 1x word
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/replication and load shift (addressed byte to [31:24]).
// Lane 3 holds offset 0 (big-lane-first).
module lsu_lane_align
    import fewcore_pkg::*;
(
    input  logic        is_store_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  rd_offset_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_shift_o
);

    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = store_data_i;
        case (size_i)
            2'b00: begin
                wmask_o = 4'b1000 >> offset_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                wmask_o = 4'b1100 >> offset_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                wmask_o = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
        if (!is_store_i) begin
            wmask_o = 4'b0000;
        end
    end

    assign rdata_shift_o = rdata_i << {rd_offset_i, 3'b000};

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decode, alignment check, handshaked memory request and no-ack watchdog.
//  state | meaning
//  IDLE  | waiting for a valid aligned load/store in EX
//  REQ   | mem_req high, payload held, waiting for mem_ack or watchdog
//  DONE  | one cycle: EX retires, load_data valid
module lsu_ctrl
    import fewcore_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_funct_hi;
    logic       is_load_op;
    logic       is_store_op;
    logic       mem_op;
    logic       aligned;
    logic       start;
    logic       misal_det;

    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic [31:0] rd_shift;

    lsu_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            misal_q, misal_d;
    logic            bus_err_q, bus_err_d;

    assign opcode          = operation[6:0];
    assign funct3          = operation[9:7];
    assign unused_funct_hi = ^operation[11:10];

    assign is_load_op  = (opcode == OP_LOAD)  && f3_valid(1'b0, funct3);
    assign is_store_op = (opcode == OP_STORE) && f3_valid(1'b1, funct3);
    assign mem_op      = ex_valid && (is_load_op || is_store_op);
    assign aligned     = is_aligned(funct3[1:0], addr[1:0]);
    assign start       = mem_op && (state_q == IDLE) && aligned;
    assign misal_det   = mem_op && (state_q == IDLE) && !aligned;

    lsu_lane_align u_align (
        .is_store_i    (is_store_op),
        .size_i        (funct3[1:0]),
        .offset_i      (addr[1:0]),
        .store_data_i  (store_data[31:0]),
        .rd_offset_i   (off_q),
        .rdata_i       (mem_rdata),
        .wmask_o       (al_wmask),
        .wdata_o       (al_wdata),
        .rdata_shift_o (rd_shift)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        misal_d     = misal_det;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    state_d = REQ;
                    // counter holds the index of the current REQ cycle, starting at 1
                    cnt_d   = 8'd1;
                    we_d    = is_store_op;
                    addr_d  = {addr[XLEN-1:2], 2'b00};
                    wdata_d = al_wdata;
                    wmask_d = al_wmask;
                    off_d   = addr[1:0];
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        load_data_d = XLEN'(rd_shift);
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d     = DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
            off_q       <= 2'd0;
            load_data_q <= '0;
            misal_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            misal_q     <= misal_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall      = start || (state_q == REQ);
    assign mem_req    = (state_q == REQ);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wmask  = wmask_q;
    assign load_data  = load_data_q;
    assign misaligned = misal_q;
    assign bus_err    = bus_err_q;

endmodule
